// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - priority interrupt controller with edge latching, masking and IACK timeout
// Optional IRQ_CTRL_STATS_EN adds a saturating irq_count of retired requests.
module irq_ctrl #(
  parameter int NSRC    = 8,
  parameter int IDW     = 3,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  input  logic            mask_we,
  input  logic [NSRC-1:0] mask_wdata,
  output logic [NSRC-1:0] mask,
  output logic [NSRC-1:0] pending,
  output logic            IRQ,
  input  logic            IACK,
  output logic [IDW-1:0]  irq_id,
  output logic            timeout_err
`ifdef IRQ_CTRL_STATS_EN
  ,
  output logic [15:0]     irq_count
`endif
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, ACKW} state_t;

  state_t          state, state_n;
  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] edge_det;
  logic [NSRC-1:0] eligible;
  logic [NSRC-1:0] ack_clr;
  logic [IDW-1:0]  sel;
  logic            take;
  logic            retire;
  logic [CW-1:0]   cnt;

  assign edge_det = src & ~src_q;
  assign eligible = pending & mask;

  // Lowest index wins: scan downwards so the last match is the smallest index.
  always_comb begin
    sel = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (eligible[i]) sel = IDW'(i);
    end
  end

  always_comb begin
    state_n = state;
    take    = 1'b0;
    retire  = 1'b0;
    ack_clr = '0;
    case (state)
      IDLE: begin
        if (|eligible) begin
          state_n = REQ;
          take    = 1'b1;
        end
      end
      REQ: begin
        if (IACK) begin
          state_n = ACKW;
          retire  = 1'b1;
          ack_clr = NSRC'(1) << irq_id;
        end
      end
      ACKW: begin
        if (!IACK) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      src_q       <= '0;
      mask        <= '0;
      pending     <= '0;
      IRQ         <= 1'b0;
      irq_id      <= '0;
      timeout_err <= 1'b0;
      cnt         <= '0;
    end else begin
      state <= state_n;
      src_q <= src;
      if (mask_we) mask <= mask_wdata;
      // A fresh edge on the source being retired re-arms it (set beats clear).
      pending <= (pending & ~ack_clr) | edge_det;
      IRQ     <= (state_n == REQ);
      if (take) begin
        irq_id <= sel;
        cnt    <= '0;
      end else if (state == REQ && !IACK) begin
        if (cnt != CW'(TIMEOUT)) cnt <= cnt + 1'b1;
        if (cnt == CW'(TIMEOUT - 1)) timeout_err <= 1'b1;
      end
    end
  end

`ifdef IRQ_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_count <= '0;
    end else if (retire && irq_count != 16'hFFFF) begin
      irq_count <= irq_count + 16'd1;
    end
  end
`else
  logic unused_retire;
  assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - scoreboard testbench for irq_ctrl (IRQ_CTRL_STATS_EN optional)
module tb_irq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] src;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic [7:0] mask;
  logic [7:0] pending;
  logic       IRQ;
  logic       IACK;
  logic [2:0] irq_id;
  logic       timeout_err;
`ifdef IRQ_CTRL_STATS_EN
  logic [15:0] irq_count;
`endif

  int errors = 0;
  int checks = 0;
  logic [2:0] exp_q[$];
  logic irq_prev = 1'b0;

  irq_ctrl #(.NSRC(8), .IDW(3), .TIMEOUT(64)) dut (
    .clk(clk),
    .reset(reset),
    .src(src),
    .mask_we(mask_we),
    .mask_wdata(mask_wdata),
    .mask(mask),
    .pending(pending),
    .IRQ(IRQ),
    .IACK(IACK),
    .irq_id(irq_id),
    .timeout_err(timeout_err)
`ifdef IRQ_CTRL_STATS_EN
    ,
    .irq_count(irq_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic write_mask(input logic [7:0] m);
    mask_we = 1'b1;
    mask_wdata = m;
    step();
    mask_we = 1'b0;
  endtask

  task automatic ack();
    IACK = 1'b1;
    step();
    IACK = 1'b0;
    step();
  endtask

  // Monitor: every IRQ rising edge must match the next expected source ID.
  always @(negedge clk) begin
    if (IRQ && !irq_prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL irq_unexpected: got id %0d expected none", irq_id);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        if (irq_id !== e) begin
          errors++;
          $display("FAIL irq_id: got %0d expected %0d", irq_id, e);
        end
      end
    end
    irq_prev <= IRQ;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; src = '0; mask_we = 1'b0; mask_wdata = '0; IACK = 1'b0;
    step(2);
    reset = 1'b0;
    chk("rst_irq", IRQ, 0);
    chk("rst_pending", pending, 0);
    chk("rst_mask", mask, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_id", irq_id, 0);

    // single source
    write_mask(8'hFF);
    chk("mask_ff", mask, 8'hFF);
    exp_q.push_back(3'd5);
    src = 8'h20; step(); src = '0;
    chk("t1_pending", pending, 8'h20);
    chk("t1_irq_lo", IRQ, 0);
    step();
    chk("t1_irq_hi", IRQ, 1);
    IACK = 1'b1; step(); IACK = 1'b0;
    chk("t1_irq_ack", IRQ, 0);
    chk("t1_pend_clr", pending, 0);
    step();

    // priority
    exp_q.push_back(3'd2); exp_q.push_back(3'd6);
    src = 8'h44; step(); src = '0;
    step();
    chk("t2_pending", pending, 8'h44);
    IACK = 1'b1; step(); IACK = 1'b0;
    chk("t2_pend_after", pending, 8'h40);
    step();
    chk("t2_gap", IRQ, 0);
    step();
    chk("t2_irq6", IRQ, 1);
    ack();
    chk("t2_pend_clr", pending, 0);
    step();

    // masked pending
    write_mask(8'h00);
    src = 8'h08; step(); src = '0;
    step(2);
    chk("t3_irq_masked", IRQ, 0);
    chk("t3_pending", pending, 8'h08);
    exp_q.push_back(3'd3);
    write_mask(8'h08);
    chk("t3_irq_wait", IRQ, 0);
    step();
    chk("t3_irq_hi", IRQ, 1);
    ack();

    // long IACK retires only one request
    write_mask(8'hFF);
    exp_q.push_back(3'd1); exp_q.push_back(3'd4);
    src = 8'h12; step(); src = '0;
    step();
    IACK = 1'b1;
    step(10);
    chk("t5_irq_lo", IRQ, 0);
    chk("t5_pending", pending, 8'h10);
    IACK = 1'b0;
    step();
    chk("t5_gap", IRQ, 0);
    step();
    chk("t5_irq4", IRQ, 1);
    ack();
    step();

    // new edge on the same source as its IACK: set wins
    exp_q.push_back(3'd0);
    src = 8'h01; step(); src = '0;
    step();
    exp_q.push_back(3'd0);
    src = 8'h01; IACK = 1'b1; step(); src = '0; IACK = 1'b0;
    chk("sw_pending", pending, 8'h01);
    chk("sw_irq_lo", IRQ, 0);
    step(2);
    chk("sw_irq_hi", IRQ, 1);
    ack();
    chk("sw_pend_clr", pending, 0);
    step();
    // IACK while idle is ignored
    IACK = 1'b1; step(2); IACK = 1'b0;
    chk("idle_iack", IRQ, 0);

    // timeout
    exp_q.push_back(3'd0);
    src = 8'h01; step(); src = '0;
    step();
    chk("t4_irq_hi", IRQ, 1);
    step(63);
    chk("t4_terr_early", timeout_err, 0);
    step();
    chk("t4_terr", timeout_err, 1);
    chk("t4_irq_still", IRQ, 1);
    src = 8'h02; step(); src = '0;
    chk("t4_pending", pending, 8'h03);
    chk("t4_terr_sticky", timeout_err, 1);
`ifdef IRQ_CTRL_STATS_EN
    chk("stats_count", irq_count, 16'd8);
`endif

    // reset mid-REQ
    reset = 1'b1; step(); reset = 1'b0;
    chk("t6_irq", IRQ, 0);
    chk("t6_pending", pending, 0);
    chk("t6_mask", mask, 0);
    chk("t6_terr", timeout_err, 0);
`ifdef IRQ_CTRL_STATS_EN
    chk("t6_count", irq_count, 0);
`endif
    step(3);
    chk("t6_irq_stays", IRQ, 0);
    chk("sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
